// File: rtl/rtc_shadow_pkg.sv
// Shared constants for the RTC shadow: field indices, control-bit masks, read map, FSM states.
package rtc_shadow_pkg;

  localparam logic [2:0] FLD_SS = 3'd0;
  localparam logic [2:0] FLD_MI = 3'd1;
  localparam logic [2:0] FLD_HH = 3'd2;
  localparam logic [2:0] FLD_WD = 3'd3;
  localparam logic [2:0] FLD_DD = 3'd4;
  localparam logic [2:0] FLD_MO = 3'd5;
  localparam logic [2:0] FLD_YY = 3'd6;

  localparam logic [2:0] ADDR_SS = 3'd0;
  localparam logic [2:0] ADDR_MS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Strips MCP7940N control bits (ST, 12/24, OSCRUN, LPYR, ...) from each raw byte.
  function automatic logic [7:0] field_mask(input logic [2:0] idx);
    case (idx)
      FLD_SS:  return 8'h7F;
      FLD_MI:  return 8'h7F;
      FLD_HH:  return 8'h3F;
      FLD_WD:  return 8'h07;
      FLD_DD:  return 8'h3F;
      FLD_MO:  return 8'h1F;
      FLD_YY:  return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rtc_shadow_bcd8_to_bin.sv
// Combinational two-digit BCD to binary, flagging any nibble above 9.
module bcd8_to_bin (
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       bad
);

  logic [3:0] tens;
  logic [3:0] units;

  assign tens  = bcd[7:4];
  assign units = bcd[3:0];
  assign bin   = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};
  assign bad   = (tens > 4'd9) | (units > 4'd9);

endmodule

// File: rtl/rtc_shadow.sv
// Shadows the RTC's BCD datetime as validated binary, adds a ms sub-count,
// and serves a coherent snapshot to the CPU bus.
//   state     | meaning
//   ST_IDLE   | waiting for a tick edge
//   ST_CONV   | converting field idx_q (0..6), one per clk
//   ST_COMMIT | publish work_q if no bad digit was seen
module rtc_shadow
  import rtc_shadow_pkg::*;
#(
  parameter int c_clk_mhz  = 25,
  parameter int c_stale_ms = 2000,
  parameter int c_ms_div   = c_clk_mhz * 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [55:0] datetime,
  input  logic        rd,
  input  logic [2:0]  addr,
  output logic [15:0] rdata,
  output logic        valid,
  output logic        bcd_err,
  output logic        stale,
  output logic        update,
  output logic [9:0]  ms
);

  localparam int            PW       = (c_ms_div > 1) ? $clog2(c_ms_div) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(c_ms_div - 1);
  localparam logic [11:0]   STALE_TH = 12'(c_stale_ms);
  localparam logic [9:0]    MS_MAX   = 10'd999;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic             err_q;
  logic [55:0]      raw_q;
  logic [6:0][6:0]  work_q;
  logic [6:0][6:0]  committed_q;
  logic             update_q, valid_q, bcd_err_q;

  logic             tick_q, tick_d, tick_r;
  logic [PW-1:0]    presc_q, presc_d;
  logic [9:0]       ms_q, ms_d;
  logic [11:0]      stale_cnt_q, stale_cnt_d;
  logic             stale_q, stale_d;
  logic [6:0][6:0]  snap_q, snap_d;
  logic [9:0]       snap_ms_q, snap_ms_d;
  logic [15:0]      rdata_q, rdata_d;

  logic [7:0]       fld_masked;
  logic [6:0]       fld_bin;
  logic             fld_bad;

  assign tick_r     = tick & ~tick_q;
  assign fld_masked = raw_q[{idx_q, 3'b000} +: 8] & field_mask(idx_q);

  bcd8_to_bin u_conv (
    .bcd (fld_masked),
    .bin (fld_bin),
    .bad (fld_bad)
  );

  // A tick edge in any state restarts conversion, discarding partial work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      raw_q       <= '0;
      work_q      <= '0;
      committed_q <= '0;
      update_q    <= 1'b0;
      valid_q     <= 1'b0;
      bcd_err_q   <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if (tick_r) begin
        state_q <= ST_CONV;
        raw_q   <= datetime;
        idx_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_CONV: begin
            work_q[idx_q] <= fld_bin;
            err_q         <= err_q | fld_bad;
            if (idx_q == FLD_YY) state_q <= ST_COMMIT;
            else                 idx_q   <= idx_q + 3'd1;
          end
          ST_COMMIT: begin
            if (!err_q) begin
              committed_q <= work_q;
              update_q    <= 1'b1;
              valid_q     <= 1'b1;
              bcd_err_q   <= 1'b0;
            end else begin
              bcd_err_q   <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // stale is sticky from reset until the first tick, then tracks stale_cnt.
  always_comb begin
    tick_d      = tick;
    presc_d     = presc_q;
    ms_d        = ms_q;
    stale_cnt_d = stale_cnt_q;
    if (tick_r) begin
      presc_d     = PRESC_TC;
      ms_d        = '0;
      stale_cnt_d = '0;
    end else if (presc_q == '0) begin
      presc_d = PRESC_TC;
      if (ms_q != MS_MAX)       ms_d        = ms_q + 10'd1;
      if (stale_cnt_q != '1)    stale_cnt_d = stale_cnt_q + 12'd1;
    end else begin
      presc_d = presc_q - PW'(1);
    end
    stale_d = tick_r ? 1'b0 : (stale_q | (stale_cnt_d >= STALE_TH));
  end

  always_comb begin
    snap_d    = snap_q;
    snap_ms_d = snap_ms_q;
    rdata_d   = rdata_q;
    if (rd) begin
      if (addr == ADDR_SS) begin
        snap_d    = committed_q;
        snap_ms_d = ms_q;
        rdata_d   = {9'd0, committed_q[FLD_SS]};
      end else if (addr == ADDR_MS) begin
        rdata_d   = {6'd0, snap_ms_q};
      end else begin
        rdata_d   = {9'd0, snap_q[addr]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q      <= 1'b0;
      presc_q     <= PRESC_TC;
      ms_q        <= '0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b1;
      snap_q      <= '0;
      snap_ms_q   <= '0;
      rdata_q     <= '0;
    end else begin
      tick_q      <= tick_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
      snap_q      <= snap_d;
      snap_ms_q   <= snap_ms_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign valid   = valid_q;
  assign bcd_err = bcd_err_q;
  assign stale   = stale_q;
  assign update  = update_q;
  assign ms      = ms_q;

endmodule
